serial_slave_port: RTL and testbench
====================================

# serial_slave_port

Responder end of the serial bus driven by the bus masters. It deserializes a master's request frame, performs single or burst writes into a local word memory, and serializes read data back to the master, with a one-cycle acknowledge on completed writes. One instance sits behind each slave select, so a top level can connect masters to real memory targets.

## Interface
- `ADDRESS_LEN`, 12: address field width; local memory depth is 2**ADDRESS_LEN words.
- `WORD_SIZE`, 8: data word width.
- `BURST_SIZE`, 12: burst field is BURST_SIZE+1 bits wide.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  master drives high for every bit of a request frame.
- `rx_bit`  in  1  serial request bit, sampled when `rx_valid`=1.
- `tx_valid`  out  1  high while the slave drives `tx_bit`.
- `tx_bit`  out  1  serial response bit: read data, or the write acknowledge.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Frame format, all fields LSB first, one bit per cycle, `rx_valid` held high for the whole frame:
  - rw: 1 bit, 1 = write.
  - address: ADDRESS_LEN bits.
  - burst: BURST_SIZE+1 bits.
  - Write frames only: burst × WORD_SIZE data bits.
- Word count is the burst value, except burst=0, which transfers 1 word.
- States: IDLE, ADDR, BURST, WDATA, TURN, RDATA, ACK.
- IDLE:
  - `rx_valid`=1 samples rw and moves to ADDR.
  - A `rx_valid`=1 bit in IDLE is always the rw bit.
- ADDR and BURST each shift in their field under a bit counter.
- After the last burst bit:
  - Write goes to WDATA.
  - Read goes to TURN.
- WDATA:
  - Assembles each word.
  - The word is written to mem[addr] on the edge that samples its MSB; addr then increments.
  - After the last word, goes to ACK.
- ACK: `tx_valid`=1, `tx_bit`=1 for exactly one cycle, then IDLE.
- TURN: one cycle; registers mem[addr] into the shift register.
- RDATA:
  - Shifts the word out LSB first.
  - After each MSB, loads the next word (addr+1) with no gap between words.
  - After the last word, goes to IDLE.
  - `rx_valid` is ignored in TURN and RDATA.
- Address arithmetic: modulo 2**ADDRESS_LEN, so 0xFFF+1 wraps to 0x000.
- Abort:
  - `rx_valid`=0 in ADDR, BURST or WDATA returns to IDLE with no ACK.
  - Words already completed stay written; the partial word is discarded.
- Reset, asserted at any time:
  - Outputs: `tx_valid`=0, `tx_bit`=0, `busy`=0.
  - State returns to IDLE; counters and shift registers clear.
  - Memory contents are not reset; an in-flight read is truncated.

## Timing
- Header length H = 2 + ADDRESS_LEN + BURST_SIZE bits (26 at default parameters).
- Read latency:
  - Last header bit sampled at edge k; TURN occupies cycle k..k+1.
  - `tx_valid` is high from edge k+1, first data bit valid.
  - Stays high for exactly words × WORD_SIZE cycles, then drops.
- Write: ACK pulse is high the cycle after the edge that samples the final data bit.
- Master may start a new frame the cycle after `busy` falls; back-to-back frames need no idle cycle beyond this.
- `busy` rises on the edge that samples rw and falls on the edge that leaves ACK or RDATA.
- `tx_bit`=0 whenever `tx_valid`=0.

## Test plan
- Reset: hold `rst`=0 with `rx_valid` toggling -> `tx_valid`=0, `busy`=0 throughout; release -> IDLE.
- Single write, then read back:
  - Write addr 0x042, burst 1, data 0x78 -> one-cycle ACK (`tx_bit`=1) one cycle after the data MSB.
  - Read addr 0x042, burst 1 -> `tx_valid` high for 8 cycles starting 1 cycle after the header, bits 0,0,0,1,1,1,1,0.
- Burst wrap:
  - Write addr 0xFFE, burst 3, data 0x11/0x22/0x33 -> locations 0xFFE/0xFFF/0x000.
  - Read addr 0xFFE, burst 3 -> 24 contiguous `tx_valid` cycles returning 0x11, 0x22, 0x33.
- Burst 0: write addr 0x010, burst 0, data 0xA5 -> exactly one word written, ACK.
  - Read back -> 8 bits of 0xA5 only.
- Abort:
  - Write addr 0x020, burst 2; drop `rx_valid` after 12 data bits -> no ACK, `busy` falls next cycle.
  - Read 0x020/0x021 -> first word new, second word unchanged.
- Reset mid-read: assert `rst` during RDATA bit 3 -> `tx_valid`=0 immediately (asynchronously).
  - After release, rereading returns the stored data intact.

Source files
------------

// File: rtl/serial_slave_port.sv
// Serial bus responder: deserializes request frames, does single/burst writes into a local
// word memory with a one-cycle ACK, and serializes read data back to the master.
`timescale 1ns/1ps
module serial_slave_port #(
  parameter int unsigned ADDRESS_LEN = 12,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned BURST_SIZE  = 12
) (
  input  logic clock,
  input  logic rst,
  input  logic rx_valid,
  input  logic rx_bit,
  output logic tx_valid,
  output logic tx_bit,
  output logic busy
);

  localparam int unsigned BurstLen = BURST_SIZE + 1;
  localparam int unsigned MaxAb    = (ADDRESS_LEN > BurstLen) ? ADDRESS_LEN : BurstLen;
  localparam int unsigned MaxLen   = (MaxAb > WORD_SIZE) ? MaxAb : WORD_SIZE;
  localparam int unsigned CntW     = $clog2(MaxLen + 1);

  localparam logic [CntW-1:0] AddrLast  = CntW'(ADDRESS_LEN - 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(BurstLen - 1);
  localparam logic [CntW-1:0] WordLast  = CntW'(WORD_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StBurst, StWdata, StTurn, StRdata, StAck} state_e;

  state_e                  state;
  logic                    rw;
  logic [ADDRESS_LEN-1:0]  addr;
  logic [BurstLen-2:0]     burst_lo;
  logic [BurstLen-1:0]     words_left;
  logic [CntW-1:0]         bit_cnt;
  logic [WORD_SIZE-1:0]    shreg;
  logic [WORD_SIZE-1:0]    mem [2**ADDRESS_LEN];

  logic [BurstLen-1:0]     burst_full;
  logic [WORD_SIZE-1:0]    word_full;
  logic [ADDRESS_LEN-1:0]  addr_inc;
  logic [ADDRESS_LEN-1:0]  rd_addr;
  logic [WORD_SIZE-1:0]    rd_word;
  logic                    last_word;
  logic                    wr_en;

  assign burst_full = {rx_bit, burst_lo};
  assign word_full  = {rx_bit, shreg[WORD_SIZE-1:1]};
  assign addr_inc   = addr + ADDRESS_LEN'(1);
  assign last_word  = (words_left == BurstLen'(1));
  // TURN reads the current word; RDATA prefetches the next one at each MSB.
  assign rd_addr    = (state == StTurn) ? addr : addr_inc;
  assign rd_word    = mem[rd_addr];
  assign wr_en      = (state == StWdata) && rx_valid && (bit_cnt == WordLast);
  assign busy       = (state != StIdle);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= word_full;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      rw         <= 1'b0;
      addr       <= '0;
      burst_lo   <= '0;
      words_left <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_valid   <= 1'b0;
      tx_bit     <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          tx_valid <= 1'b0;
          tx_bit   <= 1'b0;
          if (rx_valid) begin
            rw      <= rx_bit;
            bit_cnt <= '0;
            state   <= StAddr;
          end
        end
        StAddr: begin
          if (!rx_valid) begin
            state <= StIdle;
          end else begin
            addr <= {rx_bit, addr[ADDRESS_LEN-1:1]};
            if (bit_cnt == AddrLast) begin
              bit_cnt <= '0;
              state   <= StBurst;
            end else begin
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
        end
        StBurst: begin
          if (!rx_valid) begin
            state <= StIdle;
          end else begin
            burst_lo <= burst_full[BurstLen-1:1];
            if (bit_cnt == BurstLast) begin
              bit_cnt    <= '0;
              words_left <= (burst_full == '0) ? BurstLen'(1) : burst_full;
              state      <= rw ? StWdata : StTurn;
            end else begin
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
        end
        StWdata: begin
          if (!rx_valid) begin
            state <= StIdle;
          end else begin
            shreg <= word_full;
            if (bit_cnt == WordLast) begin
              bit_cnt <= '0;
              if (last_word) begin
                tx_valid <= 1'b1;
                tx_bit   <= 1'b1;
                state    <= StAck;
              end else begin
                addr       <= addr_inc;
                words_left <= words_left - BurstLen'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + CntW'(1);
            end
          end
        end
        StTurn: begin
          shreg    <= rd_word >> 1;
          tx_bit   <= rd_word[0];
          tx_valid <= 1'b1;
          bit_cnt  <= '0;
          state    <= StRdata;
        end
        StRdata: begin
          if (bit_cnt == WordLast) begin
            bit_cnt <= '0;
            if (last_word) begin
              tx_valid <= 1'b0;
              tx_bit   <= 1'b0;
              state    <= StIdle;
            end else begin
              addr       <= addr_inc;
              words_left <= words_left - BurstLen'(1);
              shreg      <= rd_word >> 1;
              tx_bit     <= rd_word[0];
            end
          end else begin
            bit_cnt <= bit_cnt + CntW'(1);
            tx_bit  <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        StAck: begin
          tx_valid <= 1'b0;
          tx_bit   <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed self-checking bench for serial_slave_port: writes, reads, burst wrap, burst 0,
// abort and asynchronous reset during a read.
`timescale 1ns/1ps
module tb_serial_slave_port;

  logic clock = 1'b0;
  logic rst;
  logic rx_valid;
  logic rx_bit;
  logic tx_valid;
  logic tx_bit;
  logic busy;

  int checks = 0;
  int failures = 0;

  serial_slave_port #(
    .ADDRESS_LEN(12),
    .WORD_SIZE  (8),
    .BURST_SIZE (12)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_bit  (rx_bit),
    .tx_valid(tx_valid),
    .tx_bit  (tx_bit),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // Inputs change 1ns after the rising edge; outputs are observed at the same point.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_bit   = v[i];
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_write(input logic [11:0] a, input logic [12:0] b,
                            input logic [63:0] d, input int nbits);
    send_bits(64'(1), 1);
    send_bits(64'(a), 12);
    send_bits(64'(b), 13);
    send_bits(d, nbits);
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [12:0] b, output logic [63:0] d,
                         output int n, output logic turn_tv);
    send_bits(64'(0), 1);
    send_bits(64'(a), 12);
    send_bits(64'(b), 13);
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    turn_tv  = tx_valid;
    @(posedge clock);
    #1;
    n = 0;
    d = '0;
    while (tx_valid === 1'b1 && n < 40) begin
      if (n < 64) d[n] = tx_bit;
      n++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_bit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_valid = (i % 2 == 0);
      rx_bit   = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d tx_valid=%b busy=%b expected 0/0", i, tx_valid, busy);
      end
    end
    rx_valid = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_bit !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b tx_valid=%b tx_bit=%b expected 0/0/0",
               busy, tx_valid, tx_bit);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] v;
    v = 8'h78;
    send_bits(64'(1), 1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise busy=%b expected 1", busy);
    end
    send_bits(64'h042, 12);
    send_bits(64'(1), 13);
    send_bits(64'(v), 7);
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL early_ack tx_valid=%b expected 0", tx_valid);
    end
    send_bits(64'(v >> 7), 1);
    rx_valid = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL write_ack tx_valid=%b tx_bit=%b expected 1/1", tx_valid, tx_bit);
    end
    @(posedge clock);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ack_end tx_valid=%b busy=%b expected 0/0", tx_valid, busy);
    end
  endtask

  task automatic test_single_read();
    logic [63:0] d;
    int n;
    logic tv;
    do_read(12'h042, 13'd1, d, n, tv);
    checks++;
    if (tv !== 1'b0) begin
      failures++;
      $display("FAIL turn_quiet tx_valid=%b expected 0", tv);
    end
    checks++;
    if (n != 8 || d[7:0] !== 8'h78) begin
      failures++;
      $display("FAIL read_single len=%0d data=%h expected 8/78", n, d[7:0]);
    end
    checks++;
    if (busy !== 1'b0 || tx_bit !== 1'b0) begin
      failures++;
      $display("FAIL read_end busy=%b tx_bit=%b expected 0/0", busy, tx_bit);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    int n;
    logic tv;
    send_write(12'h100, 13'd2, 64'hBEEF, 16);
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ack tx_valid=%b tx_bit=%b expected 1/1", tx_valid, tx_bit);
    end
    @(posedge clock);
    #1;
    do_read(12'h100, 13'd2, d, n, tv);
    checks++;
    if (n != 16 || d[15:0] !== 16'hBEEF) begin
      failures++;
      $display("FAIL b2b_read len=%0d data=%h expected 16/beef", n, d[15:0]);
    end
    do_read(12'h101, 13'd1, d, n, tv);
    checks++;
    if (n != 8 || d[7:0] !== 8'hBE) begin
      failures++;
      $display("FAIL b2b_read2 len=%0d data=%h expected 8/be", n, d[7:0]);
    end
  endtask

  task automatic test_burst_wrap();
    logic [63:0] d;
    int n;
    logic tv;
    send_write(12'hFFE, 13'd3, 64'h332211, 24);
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ack tx_valid=%b tx_bit=%b expected 1/1", tx_valid, tx_bit);
    end
    @(posedge clock);
    #1;
    do_read(12'hFFE, 13'd3, d, n, tv);
    checks++;
    if (n != 24 || d[23:0] !== 24'h332211) begin
      failures++;
      $display("FAIL wrap_read len=%0d data=%h expected 24/332211", n, d[23:0]);
    end
    do_read(12'h000, 13'd1, d, n, tv);
    checks++;
    if (n != 8 || d[7:0] !== 8'h33) begin
      failures++;
      $display("FAIL wrap_loc0 len=%0d data=%h expected 8/33", n, d[7:0]);
    end
  endtask

  task automatic test_burst_zero();
    logic [63:0] d;
    int n;
    logic tv;
    send_write(12'h011, 13'd1, 64'h3C, 8);
    @(posedge clock);
    #1;
    send_write(12'h010, 13'd0, 64'hA5, 8);
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL b0_ack tx_valid=%b tx_bit=%b expected 1/1", tx_valid, tx_bit);
    end
    @(posedge clock);
    #1;
    do_read(12'h010, 13'd0, d, n, tv);
    checks++;
    if (n != 8 || d[7:0] !== 8'hA5) begin
      failures++;
      $display("FAIL b0_read len=%0d data=%h expected 8/a5", n, d[7:0]);
    end
    do_read(12'h011, 13'd1, d, n, tv);
    checks++;
    if (n != 8 || d[7:0] !== 8'h3C) begin
      failures++;
      $display("FAIL b0_neighbour len=%0d data=%h expected 8/3c", n, d[7:0]);
    end
  endtask

  task automatic test_abort();
    logic [63:0] d;
    int n;
    logic tv;
    send_write(12'h020, 13'd2, 64'hC35A, 16);
    @(posedge clock);
    #1;
    send_write(12'h020, 13'd2, 64'hF96, 12);
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre tx_valid=%b busy=%b expected 0/1", tx_valid, busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle tx_valid=%b busy=%b expected 0/0", tx_valid, busy);
    end
    do_read(12'h020, 13'd2, d, n, tv);
    checks++;
    if (n != 16 || d[15:0] !== 16'hC396) begin
      failures++;
      $display("FAIL abort_read len=%0d data=%h expected 16/c396", n, d[15:0]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] d;
    int n;
    logic tv;
    send_bits(64'(0), 1);
    send_bits(64'h042, 12);
    send_bits(64'(1), 13);
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_bit !== 1'b1) begin
      failures++;
      $display("FAIL mid_read_bit3 tx_valid=%b tx_bit=%b expected 1/1", tx_valid, tx_bit);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_bit !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset tx_valid=%b tx_bit=%b busy=%b expected 0/0/0",
               tx_valid, tx_bit, busy);
    end
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset busy=%b tx_valid=%b expected 0/0", busy, tx_valid);
    end
    do_read(12'h042, 13'd1, d, n, tv);
    checks++;
    if (n != 8 || d[7:0] !== 8'h78) begin
      failures++;
      $display("FAIL reread len=%0d data=%h expected 8/78", n, d[7:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_burst_wrap();
    test_burst_zero();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
